alu_pipe: RTL
=============

Name: alu_pipe

Overview:
- Parametrised, registered successor to the team's 8-bit combinational ALU.
- Adds valid/ready handshakes on input and output, a persistent carry flag for multi-word add-with-carry and subtract-with-borrow, and an iterative multi-bit shifter.
- Sits between the datapath operand registers and the writeback stage; one operation in flight at a time.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 4).
- CNT_W, $clog2(WIDTH)+1, width of the internal shift counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operands and opcode are valid
- in_ready  out  1  block can accept an operation this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B / shift amount
- opcode  in  4  operation select
- out_valid  out  1  result registers hold an unconsumed result
- out_ready  in  1  consumer takes the result this cycle
- alu_out  out  WIDTH  result
- alu_zero  out  1  1 when alu_out == 0 (all WIDTH bits)
- alu_carry  out  1  carry/borrow out of the operation
- alu_neg  out  1  alu_out[WIDTH-1]
- alu_err  out  1  illegal opcode was executed

Behaviour:
- Reset (clock and reset fixed as above: one clock clk; reset synchronous, active-high, named reset):
  - state=IDLE, in_ready=1, out_valid=0, alu_out=0, alu_zero=1.
  - alu_carry=0, alu_neg=0, alu_err=0, stored carry C=0.
  - Reset mid-SHIFT or mid-HOLD abandons the operation; no result is ever presented for it.
- Opcodes; result is computed WIDTH+1 bits wide, and carry = bit WIDTH unless stated:
  - 0x1 ADD: a+b.
  - 0x2 SUB: a-b; carry=1 on borrow.
  - 0x3 INC: a+1.
  - 0x4 DEC: a-1.
  - 0x5 OR, 0x6 AND, 0x7 XOR: carry=0.
  - 0x8 SHR1: carry=a[0].
  - 0x9 SHL1: carry=a[WIDTH-1].
  - 0xA NOT: ~a, carry=0.
  - 0xB NEG: ~a+1, carry=1 only when a==0.
  - 0xC ADC: a+b+C.
  - 0xD SBB: a-b-C; carry=borrow.
  - 0xE SHRN: logical right shift by b.
  - 0xF SHLN: logical left shift by b.
  - 0x0: illegal; alu_out=0, carry=0, alu_err=1. alu_err=0 for all other opcodes.
- Stored carry C:
  - Updated with alu_carry at every result load, including the illegal opcode.
  - Read only by ADC and SBB, using the value from the previous completed operation.
- Handshake:
  - Input is accepted on in_valid & in_ready.
  - in_ready = (state==IDLE) | (state==HOLD & out_ready).
  - The output is consumed on out_valid & out_ready.
  - Output registers are stable while out_valid=1 and out_ready=0.
- State machine:
  - IDLE:
    - Single-cycle op accepted -> load result registers -> HOLD.
    - SHRN/SHLN accepted with N = min(b, WIDTH) > 0 -> SHIFT, count=N.
    - SHRN/SHLN with N=0 -> result=a, carry=0 -> HOLD.
  - SHIFT:
    - One bit position per cycle; carry tracks the last bit shifted out.
    - count decrements each cycle; after the final bit -> HOLD.
    - in_ready=0 throughout.
    - b >= WIDTH gives a result of 0, with carry = the last bit shifted out (a[WIDTH-1] for SHRN, a[0] for SHLN).
  - HOLD:
    - out_valid=1.
    - out_ready with no new input -> IDLE.
    - out_ready with an accepted input -> behaves as IDLE acceptance in the same cycle (back-to-back, no bubble).
- Latency:
  - Single-cycle ops: out_valid asserts the cycle after acceptance.
  - SHRN/SHLN: out_valid asserts N+1 cycles after acceptance.
- Flags:
  - alu_zero is computed on the WIDTH-bit result only; carry does not affect it.
  - alu_neg is the result MSB.
  - All flags are registered together with alu_out.

Optional Feature:
- Macro ALU_PIPE_OVF_EN.
- When defined:
  - Extra port alu_ovf (out, 1), reset 0, registered with alu_out.
  - Signed overflow for ADD/ADC/INC: operands share a sign and the result sign differs.
  - For SUB/SBB/DEC: operand signs differ and the result sign differs from a.
  - For NEG: a == 100..0.
  - 0 for all other opcodes.
- When not defined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan (WIDTH=8):
- reset, then ADD a=0xFF b=0x01, out_ready=1 -> next cycle out_valid=1, alu_out=0x00, alu_carry=1, alu_zero=1.
- ADD 0xFF+0x01, then ADC 0x00+0x00 back-to-back -> second alu_out=0x01, carry=0, with no idle cycle between results.
- SUB 0x10-0x20 -> alu_out=0xF0, carry=1, alu_neg=1; then SBB 0x05-0x01 -> alu_out=0x03.
- SHRN a=0x81 b=3 -> in_ready=0 for 3 cycles; result 0x10, carry=0, out_valid on cycle 4. SHLN a=0x81 b=9 -> 0x00, carry=1, after 9 cycles.
- out_ready=0 for 5 cycles after a result -> alu_out and flags are stable, in_ready=0; opcode 0x0 -> alu_err=1, alu_out=0.
- reset asserted during SHIFT of SHRN b=6 -> next cycle state=IDLE, out_valid=0, C=0; with ALU_PIPE_OVF_EN, ADD 0x7F+0x01 -> alu_ovf=1.

Source files
------------

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes, a stored carry for multi-word
// arithmetic and an iterative shifter. Define ALU_PIPE_OVF_EN to add alu_ovf.
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             alu_zero,
  output logic             alu_carry,
  output logic             alu_neg,
`ifdef ALU_PIPE_OVF_EN
  output logic             alu_ovf,
`endif
  output logic             alu_err
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_INC  = 4'h3;
  localparam logic [3:0] OP_DEC  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_SHR1 = 4'h8;
  localparam logic [3:0] OP_SHL1 = 4'h9;
  localparam logic [3:0] OP_NOT  = 4'hA;
  localparam logic [3:0] OP_NEG  = 4'hB;
  localparam logic [3:0] OP_ADC  = 4'hC;
  localparam logic [3:0] OP_SBB  = 4'hD;
  localparam logic [3:0] OP_SHRN = 4'hE;
  localparam logic [3:0] OP_SHLN = 4'hF;

  localparam logic [WIDTH-1:0] WIDTH_B = WIDTH'(WIDTH);
  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [WIDTH:0]   ONE_X   = (WIDTH+1)'(1);

  state_t           state, state_next;
  logic             stored_c;
  logic [WIDTH-1:0] shift_reg;
  logic             shift_left;
  logic [CNT_W-1:0] count;

  logic             accept;
  logic             is_shift_op;
  logic             start_shift;
  logic [CNT_W-1:0] shift_n;
  logic [WIDTH:0]   res;
  logic             res_err;
  logic [WIDTH-1:0] shift_next;
  logic             shift_bit;
  logic             last_shift;

  logic             load_en;
  logic [WIDTH-1:0] load_val;
  logic             load_carry;
  logic             load_err;
  logic             load_from_shift;

  assign accept      = in_valid & in_ready;
  assign is_shift_op = (opcode == OP_SHRN) || (opcode == OP_SHLN);
  assign shift_n     = (in_b >= WIDTH_B) ? WIDTH_C : in_b[CNT_W-1:0];
  assign start_shift = is_shift_op && (shift_n != '0);

  // Result is formed one bit wider than the operands; the top bit is the carry/borrow.
  always_comb begin
    res     = '0;
    res_err = 1'b0;
    case (opcode)
      OP_ADD:  res = {1'b0, in_a} + {1'b0, in_b};
      OP_SUB:  res = {1'b0, in_a} - {1'b0, in_b};
      OP_INC:  res = {1'b0, in_a} + ONE_X;
      OP_DEC:  res = {1'b0, in_a} - ONE_X;
      OP_OR:   res = {1'b0, in_a | in_b};
      OP_AND:  res = {1'b0, in_a & in_b};
      OP_XOR:  res = {1'b0, in_a ^ in_b};
      OP_SHR1: res = {in_a[0], 1'b0, in_a[WIDTH-1:1]};
      OP_SHL1: res = {in_a, 1'b0};
      OP_NOT:  res = {1'b0, ~in_a};
      OP_NEG:  res = {1'b0, ~in_a} + ONE_X;
      OP_ADC:  res = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, stored_c};
      OP_SBB:  res = {1'b0, in_a} - {1'b0, in_b} - {{WIDTH{1'b0}}, stored_c};
      OP_SHRN,
      OP_SHLN: res = {1'b0, in_a};
      default: begin
        res     = '0;
        res_err = 1'b1;
      end
    endcase
  end

  always_comb begin
    shift_next = shift_left ? {shift_reg[WIDTH-2:0], 1'b0} : {1'b0, shift_reg[WIDTH-1:1]};
    shift_bit  = shift_left ? shift_reg[WIDTH-1] : shift_reg[0];
    last_shift = (count == CNT_ONE);
  end

  // A result load comes either from a single-cycle acceptance or the final shift step.
  always_comb begin
    load_en         = 1'b0;
    load_from_shift = 1'b0;
    load_val        = res[WIDTH-1:0];
    load_carry      = res[WIDTH];
    load_err        = res_err;
    if (accept && !start_shift) begin
      load_en = 1'b1;
    end else if (!accept && state == SHIFT && last_shift) begin
      load_en         = 1'b1;
      load_from_shift = 1'b1;
      load_val        = shift_next;
      load_carry      = shift_bit;
      load_err        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = start_shift ? SHIFT : HOLD;
        end
      end
      SHIFT: begin
        if (last_shift) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            state_next = start_shift ? SHIFT : HOLD;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_out    <= '0;
      alu_zero   <= 1'b1;
      alu_carry  <= 1'b0;
      alu_neg    <= 1'b0;
      alu_err    <= 1'b0;
      stored_c   <= 1'b0;
      shift_reg  <= '0;
      shift_left <= 1'b0;
      count      <= '0;
    end else begin
      if (accept && start_shift) begin
        shift_reg  <= in_a;
        shift_left <= (opcode == OP_SHLN);
        count      <= shift_n;
      end else if (state == SHIFT) begin
        shift_reg <= shift_next;
        count     <= count - CNT_ONE;
      end
      if (load_en) begin
        alu_out   <= load_val;
        alu_zero  <= (load_val == '0);
        alu_carry <= load_carry;
        alu_neg   <= load_val[WIDTH-1];
        alu_err   <= load_err;
        stored_c  <= load_carry;
      end
    end
  end

`ifdef ALU_PIPE_OVF_EN
  logic res_ovf;

  // Signed overflow; INC/DEC behave as ADD/SUB with a positive operand of one.
  always_comb begin
    res_ovf = 1'b0;
    case (opcode)
      OP_ADD, OP_ADC:
        res_ovf = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (res[WIDTH-1] != in_a[WIDTH-1]);
      OP_INC:
        res_ovf = !in_a[WIDTH-1] && res[WIDTH-1];
      OP_SUB, OP_SBB:
        res_ovf = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (res[WIDTH-1] != in_a[WIDTH-1]);
      OP_DEC:
        res_ovf = in_a[WIDTH-1] && !res[WIDTH-1];
      OP_NEG:
        res_ovf = (in_a == {1'b1, {(WIDTH-1){1'b0}}});
      default: res_ovf = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_ovf <= 1'b0;
    end else if (load_en) begin
      alu_ovf <= load_from_shift ? 1'b0 : res_ovf;
    end
  end
`endif

endmodule
